// File: rtl/dm_pkg.sv
// Shared definitions for the block mover: FSM encoding, mode codes and word geometry.
package dm_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic MODE_COPY  = 1'b0;
  localparam logic MODE_FILL  = 1'b1;
  localparam int   WORD_BYTES = 4;
  localparam int   WORD_SHIFT = 2;

  // Source alignment only matters when the source is actually read.
  function automatic logic start_misaligned(input logic mode, input logic [1:0] src_lsb,
                                            input logic [1:0] dst_lsb);
    return (dst_lsb != 2'b00) || ((mode == MODE_COPY) && (src_lsb != 2'b00));
  endfunction

endpackage

// File: rtl/dm_addr_gen.sv
// Source/destination word pointers and remaining-word counter for the block mover.
// Next-pointer values are exported so the top can register the outgoing address.
module dm_addr_gen
  import dm_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic [ADDR_WIDTH-1:0] src_i,
  input  logic [ADDR_WIDTH-1:0] dst_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  output logic [ADDR_WIDTH-1:0] src_nxt_o,
  output logic [ADDR_WIDTH-1:0] dst_nxt_o,
  output logic                  last_o
);

  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;

  always_comb begin
    src_d = src_q;
    dst_d = dst_q;
    cnt_d = cnt_q;
    if (load_i) begin
      src_d = src_i;
      dst_d = dst_i;
      cnt_d = len_i;
    end else if (step_i) begin
      // Pointers wrap silently at the top of the address space.
      src_d = src_q + ADDR_WIDTH'(WORD_BYTES);
      dst_d = dst_q + ADDR_WIDTH'(WORD_BYTES);
      cnt_d = cnt_q - LEN_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      src_q <= '0;
      dst_q <= '0;
      cnt_q <= '0;
    end else begin
      src_q <= src_d;
      dst_q <= dst_d;
      cnt_q <= cnt_d;
    end
  end

  assign src_nxt_o = src_d;
  assign dst_nxt_o = dst_d;
  assign last_o    = (cnt_q == LEN_WIDTH'(1));

endmodule

// File: rtl/dm_block_mover.sv
// Word-granular block copy / fill engine driving the data_memory port.
// Copy takes 2 cycles per word (RD then WR), fill 1; start is ignored while busy.
module dm_block_mover
  import dm_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  input  logic                  start_i,
  input  logic                  mode_i,
  input  logic [ADDR_WIDTH-1:0] src_addr_i,
  input  logic [ADDR_WIDTH-1:0] dst_addr_i,
  input  logic [LEN_WIDTH-1:0]  length_i,
  input  logic [DATA_WIDTH-1:0] fill_data_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [ADDR_WIDTH-1:0] mem_address_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  mem_write_o,
  output logic                  mem_read_o,
  input  logic [DATA_WIDTH-1:0] mem_read_data_i
);

  state_e                state_q, state_d;
  logic                  mode_q, mode_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic                  start_acc;
  logic                  bad_align;
  logic                  last;
  logic [ADDR_WIDTH-1:0] src_nxt, dst_nxt;

  assign start_acc = (state_q == S_IDLE) && start_i;
  assign bad_align = start_misaligned(mode_i, src_addr_i[1:0], dst_addr_i[1:0]);

  dm_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .LEN_WIDTH (LEN_WIDTH)
  ) u_addr_gen (
    .clk_i    (clock_i),
    .rst_n_i  (reset_n_i),
    .load_i   (start_acc),
    .step_i   (state_q == S_WR),
    .src_i    (src_addr_i),
    .dst_i    (dst_addr_i),
    .len_i    (length_i),
    .src_nxt_o(src_nxt),
    .dst_nxt_o(dst_nxt),
    .last_o   (last)
  );

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_COPY;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (bad_align || (length_i == '0)) state_d = S_DONE;
          else if (mode_i == MODE_FILL)      state_d = S_WR;
          else                               state_d = S_RD;
        end
      end
      S_RD:    state_d = S_WR;
      S_WR: begin
        if (last)                     state_d = S_DONE;
        else if (mode_q == MODE_FILL) state_d = S_WR;
        else                          state_d = S_RD;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output registers are decoded from the next state so strobes align with the state.
  always_comb begin
    rd_d   = (state_d == S_RD);
    wr_d   = (state_d == S_WR);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    err_d  = start_acc ? bad_align : err_q;
    mode_d = start_acc ? mode_i : mode_q;
    addr_d = addr_q;
    if (rd_d)      addr_d = src_nxt;
    else if (wr_d) addr_d = dst_nxt;
    data_d = data_q;
    if ((state_q == S_WR) && (mode_q == MODE_COPY))   data_d = mem_read_data_i;
    else if (start_acc && (state_d == S_WR))          data_d = fill_data_i;
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign error_o       = err_q;
  assign mem_read_o    = rd_q;
  assign mem_write_o   = wr_q;
  assign mem_address_o = addr_q;
  // Copy writes forward the read word in the same cycle; otherwise hold the last value.
  assign mem_data_o    = (wr_q && (mode_q == MODE_COPY)) ? mem_read_data_i : data_q;

endmodule

// File: tb/tb_dm_block_mover.sv
// Randomized bench for dm_block_mover against an array model of an 8-word data_memory.
module tb_dm_block_mover;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        mode;
  logic [31:0] src_addr, dst_addr, fill_data;
  logic [15:0] length;
  logic        busy, done, error;
  logic [31:0] mem_address, mem_data, rdata;
  logic        mem_write, mem_read;

  logic [31:0] mem [8];
  logic        preload_req;
  logic [31:0] mm  [8];
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;

  dm_block_mover dut (
    .clock_i        (clock),
    .reset_n_i      (reset_n),
    .start_i        (start),
    .mode_i         (mode),
    .src_addr_i     (src_addr),
    .dst_addr_i     (dst_addr),
    .length_i       (length),
    .fill_data_i    (fill_data),
    .busy_o         (busy),
    .done_o         (done),
    .error_o        (error),
    .mem_address_o  (mem_address),
    .mem_data_o     (mem_data),
    .mem_write_o    (mem_write),
    .mem_read_o     (mem_read),
    .mem_read_data_i(rdata)
  );

  always @(posedge clock) begin
    if (preload_req) begin
      for (int i = 0; i < 8; i++) mem[i] <= 32'(i);
    end else begin
      if (mem_write) mem[mem_address[4:2]] <= mem_data;
      if (mem_read)  rdata <= mem[mem_address[4:2]];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic preload();
    @(negedge clock);
    preload_req = 1'b1;
    @(negedge clock);
    preload_req = 1'b0;
    for (int i = 0; i < 8; i++) mm[i] = 32'(i);
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < 8; i++) check($sformatf("%s_w%0d", tag, i), 64'(mem[i]), 64'(mm[i]));
  endtask

  task automatic run_op(input logic m, input logic [31:0] src, input logic [31:0] dst,
                        input logic [15:0] len, input logic [31:0] pat, input bit hold);
    bit          ex_wr  [$];
    logic [31:0] ex_adr [$];
    logic [31:0] ex_dat [$];
    logic        exp_err;
    logic [31:0] v;
    int          n, lat, cyc, k;
    bit          got_done;

    exp_err = (dst[1:0] != 2'b00) || (!m && (src[1:0] != 2'b00));
    n   = (exp_err || len == 16'd0) ? 0 : int'(len);
    lat = (n == 0) ? 1 : (m ? n + 1 : 2 * n + 1);
    for (int i = 0; i < n; i++) begin
      if (!m) begin
        ex_wr.push_back(1'b0); ex_adr.push_back(src + 32'(4 * i)); ex_dat.push_back('0);
        v = mm[3'((src >> 2) + 32'(i))];
      end else begin
        v = pat;
      end
      ex_wr.push_back(1'b1); ex_adr.push_back(dst + 32'(4 * i)); ex_dat.push_back(v);
      mm[3'((dst >> 2) + 32'(i))] = v;
    end

    @(negedge clock);
    mode = m; src_addr = src; dst_addr = dst; length = len; fill_data = pat; start = 1'b1;
    @(posedge clock); #1;
    if (!hold) start = 1'b0;
    cyc = 1; k = 0; got_done = 0;
    while (!got_done && cyc <= lat + 3) begin
      if (mem_read && mem_write) check("both_strobes", 1, 0);
      if (mem_read || mem_write) begin
        if (k < ex_wr.size()) begin
          check("strobe_kind", 64'(mem_write), 64'(ex_wr[k]));
          check("strobe_addr", 64'(mem_address), 64'(ex_adr[k]));
          if (mem_write) check("wr_data", 64'(mem_data), 64'(ex_dat[k]));
        end else begin
          check("extra_strobe", 1, 0);
        end
        k++;
      end
      check("busy", 64'(busy), 1);
      if (done) begin
        got_done = 1;
        check("done_latency", 64'(cyc), 64'(lat));
        check("error", 64'(error), 64'(exp_err));
      end else begin
        @(posedge clock); #1;
        cyc++;
      end
    end
    if (!got_done) check("done_timeout", 0, 1);
    check("strobe_count", 64'(k), 64'(ex_wr.size()));
    if (hold) begin
      @(negedge clock);
      start = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      check("idle_done", 64'(done), 0);
      check("idle_busy", 64'(busy), 0);
      check("idle_strobe", 64'(mem_read | mem_write), 0);
    end
    check("error_hold", 64'(error), 64'(exp_err));
    check_mem("mem");
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; mode = 1'b0; preload_req = 1'b0;
    src_addr = '0; dst_addr = '0; length = '0; fill_data = '0;
    #2;
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_error", 64'(error), 0);
    check("rst_rd", 64'(mem_read), 0);
    check("rst_wr", 64'(mem_write), 0);
    check("rst_addr", 64'(mem_address), 0);
    check("rst_data", 64'(mem_data), 0);
    @(negedge clock);
    reset_n = 1'b1;

    preload(); run_op(1'b0, 32'h0, 32'h10, 16'd4, 32'h0, 0);
    preload(); run_op(1'b1, 32'h0, 32'h8, 16'd3, 32'hDEADBEEF, 0);
    preload(); run_op(1'b1, 32'h0, 32'h6, 16'd2, 32'h1234, 0);
    run_op(1'b0, 32'h0, 32'h6, 16'd2, 32'h0, 0);
    run_op(1'b0, 32'h0, 32'h10, 16'd0, 32'h0, 0);
    run_op(1'b0, 32'h0, 32'h10, 16'd2, 32'h0, 1);
    run_op(1'b0, 32'h4, 32'h18, 16'd2, 32'h0, 0);

    // Reset lands in the second write cycle of a 4-word fill.
    preload();
    @(negedge clock);
    mode = 1'b1; dst_addr = 32'h8; length = 16'd4; fill_data = 32'hCAFEF00D; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    check("rst_mid_wr_before", 64'(mem_write), 1);
    reset_n = 1'b0; #1;
    check("rst_mid_wr", 64'(mem_write), 0);
    check("rst_mid_busy", 64'(busy), 0);
    check("rst_mid_done", 64'(done), 0);
    mm[2] = 32'hCAFEF00D;
    repeat (2) begin
      @(posedge clock); #1;
      check("rst_hold_done", 64'(done), 0);
    end
    @(negedge clock);
    reset_n = 1'b1;
    check_mem("rst_mem");
    run_op(1'b1, 32'h0, 32'h10, 16'd4, 32'h5A5A5A5A, 0);

    preload(); run_op(1'b0, 32'h0, 32'h4, 16'd3, 32'h0, 0);
    run_op(1'b0, 32'hFFFF_FFF8, 32'h8, 16'd3, 32'h0, 0);

    for (int t = 0; t < 40; t++) begin
      logic        rm;
      logic [31:0] rs, rd, rp;
      logic [15:0] rl;
      rm = 1'($urandom_range(0, 1));
      rs = 32'($urandom_range(0, 7)) << 2;
      rd = 32'($urandom_range(0, 7)) << 2;
      if ($urandom_range(0, 3) == 0) rs = rs | 32'hFFFF_FFE0;
      if ($urandom_range(0, 7) == 0) rd = rd | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) rs = rs | 32'($urandom_range(1, 3));
      rl = 16'($urandom_range(0, 6));
      rp = $urandom;
      run_op(rm, rs, rd, rl, rp, $urandom_range(0, 4) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
